// File: rtl/gray_count_decoder.sv
// ---------------------------------------------------------------------------
// gray_count_decoder
//
// Receiving end of a Gray-code counter link. The Gray count on gray_in may
// come from another clock domain. It passes through a synchronizer chain,
// is converted to binary, and every observed change is classified as an
// increment, a decrement or an illegal jump. A saturating counter records
// the number of illegal jumps.
//
// Parameters:
//   N            width of the Gray input and binary output (N >= 2)
//   SYNC_STAGES  synchronizer flops on gray_in (>= 1)
//   ERR_W        width of the saturating error counter
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous, active-high reset
//   gray_in  in   N      Gray count, may be asynchronous to clk
//   bin_out  out  N      registered binary value of the synchronized count
//   valid    out  1      high once a baseline has been captured
//   inc      out  1      one-cycle pulse, value advanced by +1 (mod 2^N)
//   dec      out  1      one-cycle pulse, value moved by -1 (mod 2^N)
//   wrap     out  1      one-cycle pulse on the 2^N-1 -> 0 increment
//   err      out  1      one-cycle pulse on an illegal jump (|delta| > 1)
//   err_cnt  out  ERR_W  count of err pulses, saturating at all-ones
//
// Optional feature (macro GRAY_DEC_HOLD_EN):
//   Defined   - on an illegal jump bin_out and the baseline are frozen at the
//               last good value; err pulses (and err_cnt counts) every cycle
//               until the synchronized value is back within +/-1 of it.
//   Undefined - an illegal jump produces a single err pulse and the new
//               value becomes the baseline.
// ---------------------------------------------------------------------------
module gray_count_decoder #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     gray_in,
  output logic [N-1:0]     bin_out,
  output logic             valid,
  output logic             inc,
  output logic             dec,
  output logic             wrap,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int WCNT_W = (SYNC_STAGES < 2) ? 1 : $clog2(SYNC_STAGES + 1);
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    PRIME  = 2'd1,
    TRACK  = 2'd2
  } state_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Saturating increment for the error counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  logic [N-1:0]      sync_p [SYNC_STAGES];
  logic [N-1:0]      bin_dec;
  logic [N-1:0]      prev;
  logic [N-1:0]      delta;
  logic              is_inc;
  logic              is_dec;
  logic              is_jump;
  logic [WCNT_W-1:0] warm_cnt;
  state_t            state;

  // ---- Stage p0..p(SYNC_STAGES-1): synchronizer chain on the Gray input ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_p[i] <= '0;
      end
    end else begin
      sync_p[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
    end
  end

  // ---- Decode and classify the synchronized value against the baseline ----
  always_comb begin
    bin_dec = gray_to_bin(sync_p[SYNC_STAGES-1]);
    // Modular difference: +1 and -1 (all-ones) are the only legal moves,
    // which also makes delta = 2 an illegal jump when N = 2.
    delta   = bin_dec - prev;
    is_inc  = (delta == N'(1));
    is_dec  = (delta == '1);
    is_jump = (delta != '0) && !is_inc && !is_dec;
  end

  // ---- Output stage: control FSM with registered value and event pulses ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WARMUP;
      warm_cnt <= '0;
      bin_out  <= '0;
      prev     <= '0;
      valid    <= 1'b0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      inc  <= 1'b0;
      dec  <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      case (state)
        // Wait until the synchronizer holds a real sample of gray_in
        // rather than its reset zeros.
        WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            state <= PRIME;
          end else begin
            warm_cnt <= warm_cnt + WCNT_W'(1);
          end
        end
        PRIME: begin
          bin_out <= bin_dec;
          prev    <= bin_dec;
          valid   <= 1'b1;
          state   <= TRACK;
        end
        TRACK: begin
          inc  <= is_inc;
          dec  <= is_dec;
          wrap <= is_inc && (prev == '1);
          err  <= is_jump;
          if (is_jump) begin
            err_cnt <= sat_inc(err_cnt);
          end
`ifdef GRAY_DEC_HOLD_EN
          // Freeze on the last good value until the input comes back in range.
          if (!is_jump) begin
            bin_out <= bin_dec;
            prev    <= bin_dec;
          end
`else
          // Always follow the input; a jump simply re-baselines.
          bin_out <= bin_dec;
          prev    <= bin_dec;
`endif
        end
        default: begin
          state    <= WARMUP;
          warm_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_count_decoder.sv
// ---------------------------------------------------------------------------
// tb_gray_count_decoder
//
// Directed bench for gray_count_decoder (N=4, SYNC_STAGES=2, default build).
// A second instance with ERR_W=2 shares the same stimulus to exercise error
// counter saturation.
// ---------------------------------------------------------------------------
module tb_gray_count_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;

  logic [3:0] bin_out, bin_out2;
  logic       valid, inc, dec, wrap, err;
  logic       valid2, inc2, dec2, wrap2, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;
  int n_inc, n_dec, n_wrap, n_err;

  always #5 clk = ~clk;

  gray_count_decoder #(.N(4), .SYNC_STAGES(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .bin_out(bin_out),
    .valid(valid), .inc(inc), .dec(dec), .wrap(wrap), .err(err),
    .err_cnt(err_cnt)
  );

  gray_count_decoder #(.N(4), .SYNC_STAGES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .gray_in(gray_in), .bin_out(bin_out2),
    .valid(valid2), .inc(inc2), .dec(dec2), .wrap(wrap2), .err(err2),
    .err_cnt(err_cnt2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_inc = 0; n_dec = 0; n_wrap = 0; n_err = 0;
  endtask

  // Advance one clock and sample 1 ns after the edge, tallying pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    n_inc  += int'(inc);
    n_dec  += int'(dec);
    n_wrap += int'(wrap);
    n_err  += int'(err);
  endtask

  // Apply a Gray value, let it propagate for 4 cycles and check the result.
  task automatic step(input logic [3:0] g, input int exp_bin, input int e_inc,
                      input int e_dec, input int e_wrap, input int e_err,
                      input string tag);
    gray_in = g;
    clr();
    repeat (4) tick();
    check({tag, "_bin"},  int'(bin_out), exp_bin);
    check({tag, "_inc"},  n_inc,  e_inc);
    check({tag, "_dec"},  n_dec,  e_dec);
    check({tag, "_wrap"}, n_wrap, e_wrap);
    check({tag, "_err"},  n_err,  e_err);
  endtask

  // Gray codes for binary 1..15 then 0.
  logic [3:0] up_gray [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0111, 4'b0101, 4'b0100, 4'b1100,
                               4'b1101, 4'b1111, 4'b1110, 4'b1010,
                               4'b1011, 4'b1001, 4'b1000, 4'b0000};

  // Illegal jumps 2->6->10->14->2 (each delta = 4).
  logic [3:0] jmp_gray [4] = '{4'b0101, 4'b1111, 4'b1001, 4'b0011};
  int         jmp_bin  [4] = '{6, 10, 14, 2};
  int         jmp_cnt2 [4] = '{2, 3, 3, 3};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    gray_in = 4'b0000;
    clr();
    repeat (3) tick();
    check("rst_valid",   int'(valid),   0);
    check("rst_bin",     int'(bin_out), 0);
    check("rst_err_cnt", int'(err_cnt), 0);

    // Release: valid must rise on the 3rd edge after release.
    rst = 1'b0;
    clr();
    tick();
    check("warm1_valid", int'(valid), 0);
    tick();
    check("warm2_valid", int'(valid), 0);
    tick();
    check("prime_valid", int'(valid),   1);
    check("prime_bin",   int'(bin_out), 0);
    tick();
    check("prime_pulses", n_inc + n_dec + n_wrap + n_err, 0);

    // Full upward sweep: 16 increments, one wrap at 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      step(up_gray[i], (i + 1) % 16, 1, 0, (i == 15) ? 1 : 0, 0,
           $sformatf("up%0d", i));
    end
    check("up_err_cnt", int'(err_cnt), 0);

    // Downward moves across zero: no wrap.
    step(4'b1000, 15, 0, 1, 0, 0, "dn15");
    step(4'b1001, 14, 0, 1, 0, 0, "dn14");
    step(4'b1000, 15, 1, 0, 0, 0, "re15");
    step(4'b0000,  0, 1, 0, 1, 0, "re0");

    // Illegal jump 0 -> 2 re-baselines at 2.
    step(4'b0011, 2, 0, 0, 0, 1, "jmp2");
    check("jmp2_cnt",  int'(err_cnt),  1);
    check("jmp2_cnt2", int'(err_cnt2), 1);

    // Further jumps: 8-bit counter keeps counting, 2-bit one saturates.
    for (int i = 0; i < 4; i++) begin
      step(jmp_gray[i], jmp_bin[i], 0, 0, 0, 1, $sformatf("jmp%0d", i));
      check($sformatf("jmp%0d_cnt", i),  int'(err_cnt),  i + 2);
      check($sformatf("jmp%0d_cnt2", i), int'(err_cnt2), jmp_cnt2[i]);
    end

    // Move to bin 9 (delta 7 is another jump), then reset mid-count.
    step(4'b1101, 9, 0, 0, 0, 1, "to9");
    check("to9_cnt", int'(err_cnt), 6);
    rst = 1'b1;
    tick();
    check("mid_rst_valid",   int'(valid),    0);
    check("mid_rst_bin",     int'(bin_out),  0);
    check("mid_rst_err_cnt", int'(err_cnt),  0);
    check("mid_rst_cnt2",    int'(err_cnt2), 0);
    rst = 1'b0;
    clr();
    tick();
    tick();
    check("rewarm_valid", int'(valid), 0);
    tick();
    check("reprime_valid", int'(valid),   1);
    check("reprime_bin",   int'(bin_out), 9);
    repeat (2) tick();
    check("reprime_inc", n_inc, 0);
    check("reprime_err", n_err, 0);
    check("reprime_bin_hold", int'(bin_out), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
